// File: rtl/sine_pkg.sv
// ---------------------------------------------------------------------------
// sine_pkg
// Shared definitions for the sine ROM playback block and the ROM it drives:
//   - default ROM geometry and phase/counter widths
//   - sequencer state encoding
//   - helper that turns a phase word into a ROM address (top AW bits)
// ---------------------------------------------------------------------------
package sine_pkg;

   localparam int SINE_WIDTH   = 32;   // ROM word / sample width
   localparam int SINE_DEPTH   = 64;   // ROM entries, power of two
   localparam int SINE_PHASE_W = 16;   // phase accumulator width
   localparam int SINE_CNT_W   = 16;   // period counter width

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } sine_state_e;

   // The ROM address is the most significant aw bits of a phase_w-bit phase.
   // The caller truncates the 32-bit result to its address width.
   function automatic logic [31:0] phase_to_addr(input logic [31:0] phase,
                                                 input int          phase_w,
                                                 input int          aw);
      return phase >> (phase_w - aw);
   endfunction

endpackage

// File: rtl/sine_phase_acc.sv
// ---------------------------------------------------------------------------
// sine_phase_acc
// DDS phase accumulator: holds the phase register, adds the frequency word
// on each advance, reports the carry-out and slices the ROM address.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   load         load phase with load_val (takes priority over adv)
//   load_val     start phase
//   adv          advance phase by fcw this cycle
//   fcw          frequency control word (already latched by the caller)
//   carry        carry-out of the add, qualified by adv (combinational)
//   addr         ROM address = top AW bits of the registered phase
// ---------------------------------------------------------------------------
module sine_phase_acc
   import sine_pkg::*;
#(
   parameter int PHASE_W = SINE_PHASE_W,
   parameter int AW      = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [PHASE_W-1:0] load_val,
   input  logic               adv,
   input  logic [PHASE_W-1:0] fcw,
   output logic               carry,
   output logic [AW-1:0]      addr
);

   logic [PHASE_W-1:0] phase_r;
   logic [PHASE_W:0]   sum_s;

   // One extra bit on the add exposes the modulo-2^PHASE_W wrap as a carry.
   assign sum_s = {1'b0, phase_r} + {1'b0, fcw};
   assign carry = adv & sum_s[PHASE_W];
   assign addr  = AW'(phase_to_addr(32'(phase_r), PHASE_W, AW));

   // Phase register: load on run start, advance on sample tick, else hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_r <= {PHASE_W{1'b0}};
      end else if (load) begin
         phase_r <= load_val;
      end else if (adv) begin
         phase_r <= sum_s[PHASE_W-1:0];
      end else begin
         phase_r <= phase_r;
      end
   end

endmodule

// File: rtl/sine_rom_sequencer.sv
// ---------------------------------------------------------------------------
// sine_rom_sequencer
// Plays the sine look-up ROM (registered read, 1-cycle latency) as a sample
// stream. A phase accumulator issues one ROM read per tick while running;
// returned words are captured and strobed out with sample_valid. Runs last
// n_periods full periods, or until a stop request lands on a period boundary.
// Ports:
//   clk, rst_n      clock / asynchronous active-low reset
//   start           pulse, begins a run when idle (latches fcw/phase_init/n)
//   stop            pulse, graceful stop at the next period boundary
//   tick            sample-rate enable
//   fcw             frequency control word
//   phase_init      start phase
//   n_periods       periods per burst, 0 = continuous
//   rom_en/rom_addr ROM read request (combinational from state and tick)
//   rom_data        ROM read data, valid the cycle after rom_en
//   sample          last captured ROM word
//   sample_valid    one-cycle strobe when sample updates
//   busy            high while in RUN or DRAIN
//   period_wrap     one-cycle pulse per phase carry-out
//   done            one-cycle pulse on return to IDLE
// ---------------------------------------------------------------------------
module sine_rom_sequencer
   import sine_pkg::*;
#(
   parameter  int WIDTH   = SINE_WIDTH,
   parameter  int DEPTH   = SINE_DEPTH,
   parameter  int PHASE_W = SINE_PHASE_W,
   parameter  int CNT_W   = SINE_CNT_W,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               tick,
   input  logic [PHASE_W-1:0] fcw,
   input  logic [PHASE_W-1:0] phase_init,
   input  logic [CNT_W-1:0]   n_periods,
   output logic               rom_en,
   output logic [AW-1:0]      rom_addr,
   input  logic [WIDTH-1:0]   rom_data,
   output logic [WIDTH-1:0]   sample,
   output logic               sample_valid,
   output logic               busy,
   output logic               period_wrap,
   output logic               done
);

   sine_state_e        state_r, state_s;
   logic [PHASE_W-1:0] fcw_r;
   logic [CNT_W-1:0]   n_r;
   logic [CNT_W-1:0]   period_cnt_r;
   logic [CNT_W-1:0]   cnt_inc_s;
   logic               stop_pend_r;
   logic               stop_any_s;
   logic               rd_pend_r;
   logic [WIDTH-1:0]   sample_r;
   logic               sample_valid_r;
   logic               busy_r;
   logic               period_wrap_r;
   logic               done_r;
   logic               load_s;
   logic               adv_s;
   logic               rom_en_s;
   logic               carry_s;
   logic               finish_s;
   logic [AW-1:0]      addr_s;

   sine_phase_acc #(
      .PHASE_W (PHASE_W),
      .AW      (AW)
   ) u_phase_acc (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_s),
      .load_val (phase_init),
      .adv      (adv_s),
      .fcw      (fcw_r),
      .carry    (carry_s),
      .addr     (addr_s)
   );

   assign cnt_inc_s  = period_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
   // A stop arriving on the same cycle as the boundary still counts.
   assign stop_any_s = stop_pend_r | stop;

   // Next-state logic, ROM read request and run-finish detection.
   always_comb begin
      state_s  = state_r;
      load_s   = 1'b0;
      adv_s    = 1'b0;
      rom_en_s = 1'b0;
      finish_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               load_s  = 1'b1;
               state_s = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            rom_en_s = tick;
            adv_s    = tick;
            if (tick) begin
               // fcw == 0 never wraps, so a stop request ends the run on
               // the next tick instead of waiting for a boundary.
               finish_s = (carry_s & (n_r != {CNT_W{1'b0}}) & (cnt_inc_s == n_r))
                        | (carry_s & stop_any_s)
                        | ((fcw_r == {PHASE_W{1'b0}}) & stop_any_s);
            end else begin
               finish_s = 1'b0;
            end
            if (finish_s) begin
               state_s = DRAIN;
            end else begin
               state_s = RUN;
            end
         end
         DRAIN: begin
            // DRAIN is only ever entered straight after the finishing read,
            // and rom_en is held low here, so that read is the only one in
            // flight: it is captured on this edge, making the final
            // sample_valid coincide with done.
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register plus the status pulses that are derived from it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         period_wrap_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         busy_r        <= (state_s != IDLE);
         done_r        <= (state_r == DRAIN) && (state_s == IDLE);
         period_wrap_r <= carry_s;
      end
   end

   // Run parameters, period counter and sticky stop request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcw_r        <= {PHASE_W{1'b0}};
         n_r          <= {CNT_W{1'b0}};
         period_cnt_r <= {CNT_W{1'b0}};
         stop_pend_r  <= 1'b0;
      end else if (load_s) begin
         fcw_r        <= fcw;
         n_r          <= n_periods;
         period_cnt_r <= {CNT_W{1'b0}};
         stop_pend_r  <= 1'b0;
      end else begin
         if ((state_r == RUN) && stop) begin
            stop_pend_r <= 1'b1;
         end else begin
            stop_pend_r <= stop_pend_r;
         end
         // Saturate rather than wrap in long continuous runs.
         if (carry_s && (period_cnt_r != {CNT_W{1'b1}})) begin
            period_cnt_r <= cnt_inc_s;
         end else begin
            period_cnt_r <= period_cnt_r;
         end
      end
   end

   // Read pipeline: track the outstanding ROM read and capture its data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend_r      <= 1'b0;
         sample_r       <= {WIDTH{1'b0}};
         sample_valid_r <= 1'b0;
      end else begin
         rd_pend_r <= rom_en_s;
         if (rd_pend_r) begin
            sample_r       <= rom_data;
            sample_valid_r <= 1'b1;
         end else begin
            sample_r       <= sample_r;
            sample_valid_r <= 1'b0;
         end
      end
   end

   assign rom_en       = rom_en_s;
   assign rom_addr     = addr_s;
   assign sample       = sample_r;
   assign sample_valid = sample_valid_r;
   assign busy         = busy_r;
   assign period_wrap  = period_wrap_r;
   assign done         = done_r;

endmodule

// File: tb/tb_sine_rom_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sine_rom_sequencer
// Randomised bench with an event-schedule reference model: every read at
// cycle c schedules a sample at c+2, every wrap a pulse at c+1 and the
// finishing read a done at c+2. A single compare process checks all outputs
// every cycle; scenario tasks add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_sine_rom_sequencer;
   import sine_pkg::*;

   localparam int WIDTH = 32, DEPTH = 64, PHASE_W = 16, CNT_W = 16, AW = 6;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               start = 1'b0, stop = 1'b0, tick = 1'b0;
   logic [PHASE_W-1:0] fcw = 16'h0000, phase_init = 16'h0000;
   logic [CNT_W-1:0]   n_periods = 16'h0000;
   logic               rom_en;
   logic [AW-1:0]      rom_addr;
   logic [WIDTH-1:0]   rom_data = 32'h0;
   logic [WIDTH-1:0]   sample;
   logic               sample_valid, busy, period_wrap, done;
   logic [WIDTH-1:0]   rom_mem [DEPTH];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sine_rom_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .tick(tick),
      .fcw(fcw), .phase_init(phase_init), .n_periods(n_periods),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .sample(sample), .sample_valid(sample_valid), .busy(busy),
      .period_wrap(period_wrap), .done(done)
   );

   // External ROM: registered read, one-cycle latency.
   always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp_v);
      end
   endtask

   // ---------------- reference model (written only by compare process) ---
   int          m_state = 0;          // 0 idle, 1 running, 2 draining
   int          m_phase = 0, m_fcw = 0, m_n = 0, m_cnt = 0;
   bit          m_stopreq = 0;
   logic [31:0] m_last = 32'h0;
   bit          ev_valid [8];
   logic [31:0] ev_smp [8];
   bit          ev_wrap [8];
   bit          ev_done [8];
   int          cyc = 0;
   // observations for scenario-level literal checks
   int          n_valid = 0, n_wrap = 0, n_done = 0;
   logic [31:0] last_sample = 32'h0;
   int          addr_log [$];

   initial begin : compare
      int  a, sum;
      bit  carry, fin, exp_en;
      for (int i = 0; i < 8; i++) begin
         ev_valid[i] = 0; ev_wrap[i] = 0; ev_done[i] = 0; ev_smp[i] = 32'h0;
      end
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_state = 0; m_phase = 0; m_fcw = 0; m_n = 0; m_cnt = 0;
            m_stopreq = 0; m_last = 32'h0;
            for (int k = 0; k < 4; k++) begin
               ev_valid[(cyc+k)%8] = 0; ev_wrap[(cyc+k)%8] = 0; ev_done[(cyc+k)%8] = 0;
            end
            chk("rst_rom_en", rom_en, 0);
            chk("rst_rom_addr", rom_addr, 0);
            chk("rst_sample", sample, 0);
            chk("rst_sample_valid", sample_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_period_wrap", period_wrap, 0);
            chk("rst_done", done, 0);
         end else begin
            // expectations for this cycle
            if (ev_valid[cyc%8]) m_last = ev_smp[cyc%8];
            exp_en = (m_state == 1) && tick;
            chk("sample_valid", sample_valid, ev_valid[cyc%8]);
            chk("sample", sample, m_last);
            chk("period_wrap", period_wrap, ev_wrap[cyc%8]);
            chk("done", done, ev_done[cyc%8]);
            chk("busy", busy, m_state != 0);
            chk("rom_en", rom_en, exp_en);
            if (exp_en) chk("rom_addr", rom_addr, m_phase / 1024);
            ev_valid[cyc%8] = 0; ev_wrap[cyc%8] = 0; ev_done[cyc%8] = 0;

            // observations
            if (sample_valid) begin n_valid++; last_sample = sample; end
            if (period_wrap) n_wrap++;
            if (done) n_done++;
            if (rom_en) addr_log.push_back(int'(rom_addr));

            // advance the model by one cycle
            case (m_state)
               0: if (start) begin
                     m_fcw = int'(fcw); m_phase = int'(phase_init); m_n = int'(n_periods);
                     m_cnt = 0; m_stopreq = 0; m_state = 1;
                  end
               1: begin
                     if (stop) m_stopreq = 1;
                     if (tick) begin
                        a = m_phase / 1024;
                        ev_valid[(cyc+2)%8] = 1;
                        ev_smp[(cyc+2)%8]   = rom_mem[a];
                        sum   = m_phase + m_fcw;
                        carry = (sum >= 65536);
                        m_phase = sum % 65536;
                        fin = 0;
                        if (carry) begin
                           ev_wrap[(cyc+1)%8] = 1;
                           if (m_n != 0 && m_cnt + 1 == m_n) fin = 1;
                           if (m_stopreq) fin = 1;
                           if (m_cnt < 65535) m_cnt++;
                        end
                        if (m_fcw == 0 && m_stopreq) fin = 1;
                        if (fin) begin
                           m_state = 2;
                           ev_done[(cyc+2)%8] = 1;
                        end
                     end
                  end
               default: m_state = 0;   // single drain cycle, then idle
            endcase
         end
         cyc++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_reset();
      @(posedge clk); #2;
      rst_n = 1'b0; start = 0; stop = 0; tick = 0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   // every > 0: tick every 'every' cycles; otherwise random with 'density' %.
   // stop_after >= 0: pulse stop once that many ticks have been issued.
   // disturb_at >= 0: pulse start with fresh random parameters in that cycle.
   task automatic run(input logic [15:0] f, input logic [15:0] p, input logic [15:0] n,
                      input int every, input int density, input int stop_after,
                      input int disturb_at);
      int base_done, ticks_done, i;
      bit stop_sent, fin;
      base_done = n_done; ticks_done = 0; i = 0; stop_sent = 0; fin = 0;
      @(posedge clk); #2;
      start = 1; fcw = f; phase_init = p; n_periods = n; tick = 0; stop = 0;
      @(posedge clk); #2;
      start = 0;
      // latched values must not follow the inputs from here on
      fcw = 16'($urandom); phase_init = 16'($urandom); n_periods = 16'($urandom_range(1, 9));
      while (!fin) begin
         tick  = (every > 0) ? (i % every == 0) : ($urandom_range(0, 99) < density);
         stop  = (stop_after >= 0) && !stop_sent && (ticks_done == stop_after);
         if (stop) stop_sent = 1;
         start = (i == disturb_at);
         if (tick) ticks_done++;
         @(posedge clk); #2;
         i++;
         if (n_done != base_done) fin = 1;
         else if (i > 6000) begin
            chk("run_timeout", 1, 0);
            fin = 1;
            do_reset();
         end
      end
      tick = 0; stop = 0; start = 0;
   endtask

   initial begin : stim
      int b_valid, b_wrap, b_done, b_addr, bad;
      logic [15:0] rf, rp, rn;
      int rs;
      for (int i = 0; i < DEPTH; i++) rom_mem[i] = $urandom;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // S1: one period, tick every cycle
      b_valid = n_valid; b_wrap = n_wrap; b_done = n_done; b_addr = addr_log.size();
      run(16'h0400, 16'h0000, 16'd1, 1, 0, -1, -1);
      chk("s1_samples", n_valid - b_valid, 64);
      chk("s1_wraps", n_wrap - b_wrap, 1);
      chk("s1_done", n_done - b_done, 1);
      chk("s1_reads", addr_log.size() - b_addr, 64);
      bad = 0;
      for (int i = 0; i < 64 && b_addr + i < addr_log.size(); i++)
         if (addr_log[b_addr+i] != i) bad++;
      chk("s1_addr_seq", bad, 0);
      chk("s1_last_sample", last_sample, rom_mem[63]);

      // S2: two periods, fcw 0x0800, tick every 3rd cycle
      b_valid = n_valid; b_wrap = n_wrap; b_done = n_done; b_addr = addr_log.size();
      run(16'h0800, 16'h0000, 16'd2, 3, 0, -1, -1);
      chk("s2_samples", n_valid - b_valid, 64);
      chk("s2_wraps", n_wrap - b_wrap, 2);
      chk("s2_done", n_done - b_done, 1);
      bad = 0;
      for (int i = 0; i < 64 && b_addr + i < addr_log.size(); i++)
         if (addr_log[b_addr+i] != (2*i) % 64) bad++;
      chk("s2_addr_seq", bad, 0);

      // S3: continuous, stop at address 10 -> runs to the wrap
      b_valid = n_valid; b_done = n_done;
      run(16'h0400, 16'h0000, 16'd0, 1, 0, 10, -1);
      chk("s3_samples", n_valid - b_valid, 64);
      chk("s3_last_sample", last_sample, rom_mem[63]);
      chk("s3_done", n_done - b_done, 1);
      chk("s3_busy_after", busy, 0);

      // S4: fcw 0, constant address 5, stop after 5 ticks
      b_addr = addr_log.size(); b_done = n_done;
      run(16'h0000, 16'h1400, 16'd0, 2, 0, 5, -1);
      chk("s4_reads", addr_log.size() - b_addr, 6);
      bad = 0;
      for (int i = b_addr; i < addr_log.size(); i++) if (addr_log[i] != 5) bad++;
      chk("s4_addr_const", bad, 0);
      chk("s4_done", n_done - b_done, 1);
      chk("s4_sample", sample, rom_mem[5]);

      // S5: start during RUN ignored; ticks continue through DRAIN
      b_valid = n_valid; b_addr = addr_log.size();
      run(16'h0400, 16'h0000, 16'd1, 1, 0, -1, 20);
      chk("s5_samples", n_valid - b_valid, 64);
      chk("s5_reads", addr_log.size() - b_addr, 64);

      // S6: reset mid-run aborts with no done, then a fresh S1 run
      b_done = n_done;
      @(posedge clk); #2;
      start = 1; fcw = 16'h0400; phase_init = 16'h0000; n_periods = 16'd1;
      @(posedge clk); #2;
      start = 0; tick = 1;
      repeat (30) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("s6_async_busy", busy, 0);
      chk("s6_async_rom_en", rom_en, 0);
      chk("s6_async_sample", sample, 0);
      chk("s6_async_valid", sample_valid, 0);
      chk("s6_async_done", done, 0);
      tick = 0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      chk("s6_no_done", n_done - b_done, 0);
      b_valid = n_valid; b_wrap = n_wrap; b_done = n_done; b_addr = addr_log.size();
      run(16'h0400, 16'h0000, 16'd1, 1, 0, -1, -1);
      chk("s6_samples", n_valid - b_valid, 64);
      chk("s6_wraps", n_wrap - b_wrap, 1);
      chk("s6_done", n_done - b_done, 1);
      bad = 0;
      for (int i = 0; i < 64 && b_addr + i < addr_log.size(); i++)
         if (addr_log[b_addr+i] != i) bad++;
      chk("s6_addr_seq", bad, 0);

      // Random runs, checked cycle by cycle against the model
      for (int r = 0; r < 10; r++) begin
         rf = 16'($urandom_range(16'h0100, 16'h1800));
         rp = 16'($urandom);
         rn = 16'($urandom_range(0, 3));
         rs = (rn == 0 || $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
         b_done = n_done;
         run(rf, rp, rn, 0, int'($urandom_range(30, 100)), rs,
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) : -1);
         chk("rand_done", n_done - b_done, 1);
      end

      repeat (4) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
